maze_memory: RTL and testbench

Storage and responder for the 64x64 maze grid. It answers the solver's cell-read and path-mark requests with a fixed one-cycle read latency. It is bulk-loaded from a host stream before solving and streams the marked grid back after solving. It sits between the host/testbench loader and the maze solver and owns the only copy of the grid.

---
 rtl/maze_pkg.sv | 19 +
 rtl/maze_ram_2p.sv | 26 ++
 rtl/maze_memory.sv | 177 +++++++++++++++++
 tb/tb_maze_memory.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared constants for the maze grid store.
// Cell codes, FSM state encodings and address geometry.
package maze_pkg;

    localparam int DIM    = 64;
    localparam int ADDR_W = 12;

    localparam logic [1:0] CELL_FREE = 2'd0;
    localparam logic [1:0] CELL_WALL = 2'd1;
    localparam logic [1:0] CELL_PATH = 2'd2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_SERVE = 2'd2;
    localparam state_t ST_DUMP  = 2'd3;

endpackage

// File: rtl/maze_ram_2p.sv
// 4096x2 grid RAM, registered reads on both ports, no reset.
// Port A reads; port B reads for marks and writes marks/loads.
module maze_ram_2p
    import maze_pkg::*;
(
    input  logic              clk,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [1:0]        a_rdata,
    input  logic [ADDR_W-1:0] b_raddr,
    output logic [1:0]        b_rdata,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [1:0]        b_wdata
);

    logic [1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        a_rdata <= mem[a_addr];
        b_rdata <= mem[b_raddr];
        if (b_we) begin
            mem[b_waddr] <= b_wdata;
        end
    end

endmodule

// File: rtl/maze_memory.sv
// Maze grid store: bulk load, solver read/mark service, streamed dump.
// Owns the FSM, mark pipeline with forwarding and the dump skid.
module maze_memory
    import maze_pkg::*;
#(
    parameter int DIM = maze_pkg::DIM
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_start,
    input  logic        load_valid,
    input  logic [1:0]  load_cell,
    output logic        load_ready,
    output logic        load_done,
    input  logic [5:0]  row,
    input  logic [5:0]  col,
    input  logic        maze_oe,
    input  logic        maze_we,
    output logic        maze_in,
    input  logic        dump_start,
    output logic        dump_valid,
    output logic [1:0]  dump_cell,
    input  logic        dump_ready,
    output logic        dump_done,
    output logic [11:0] path_count,
    output logic        busy
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DIM * DIM - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt, iss_cnt, m_addr, fw_addr, ra_q;
    logic [ADDR_W-1:0] addr, a_addr, b_waddr;
    logic [1:0]        a_rdata, b_rdata, b_wdata, fw_data;
    logic [1:0]        a_code, m_cur, ld_code, sk_cell, occ;
    logic              m_vld, fw_vld, rd_pend, in_q;
    logic              r_vld, sk_vld, iss_done, iss, pop;
    logic              go_load, go_dump, srv, ld_acc, m_wr, b_we;

    assign addr    = {row, col};
    assign go_load = load_start && (state != ST_DUMP);
    assign go_dump = (state == ST_SERVE) && dump_start && !load_start;
    assign srv     = (state == ST_SERVE) && !load_start && !dump_start;
    assign ld_acc  = (state == ST_LOAD) && load_valid && !load_start;
    assign ld_code = (load_cell == 2'd3) ? CELL_WALL : load_cell;

    // One-entry forward covers the write landing on the same edge as a read.
    assign m_cur = (fw_vld && fw_addr == m_addr) ? fw_data : b_rdata;
    assign a_code = (fw_vld && fw_addr == ra_q) ? fw_data : a_rdata;
    assign m_wr  = m_vld && (m_cur != CELL_WALL);

    assign b_we    = ld_acc || m_wr;
    assign b_waddr = ld_acc ? cnt : m_addr;
    assign b_wdata = ld_acc ? ld_code : CELL_PATH;

    assign pop = dump_valid && dump_ready;
    assign occ = 2'(dump_valid) + 2'(sk_vld) + 2'(r_vld) - 2'(pop);
    assign iss = (state == ST_DUMP) && !iss_done && (occ < 2'd2);

    always_comb begin
        a_addr = addr;
        if (go_dump) begin
            a_addr = '0;
        end else if (state == ST_DUMP) begin
            a_addr = iss_cnt;
        end
    end

    assign maze_in    = rd_pend ? (a_code == CELL_WALL) : in_q;
    assign load_ready = (state == ST_LOAD);
    assign busy       = (state == ST_LOAD) || (state == ST_DUMP);

    maze_ram_2p u_ram (
        .clk     (clk),
        .a_addr  (a_addr),
        .a_rdata (a_rdata),
        .b_raddr (addr),
        .b_rdata (b_rdata),
        .b_we    (b_we),
        .b_waddr (b_waddr),
        .b_wdata (b_wdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            iss_cnt    <= '0;
            iss_done   <= 1'b0;
            load_done  <= 1'b0;
            dump_done  <= 1'b0;
            path_count <= '0;
            m_vld      <= 1'b0;
            m_addr     <= '0;
            fw_vld     <= 1'b0;
            fw_addr    <= '0;
            fw_data    <= '0;
            ra_q       <= '0;
            rd_pend    <= 1'b0;
            in_q       <= 1'b0;
            r_vld      <= 1'b0;
            sk_vld     <= 1'b0;
            sk_cell    <= '0;
            dump_valid <= 1'b0;
            dump_cell  <= '0;
        end else begin
            load_done <= 1'b0;
            dump_done <= 1'b0;
            m_vld     <= srv && maze_we;
            m_addr    <= addr;
            rd_pend   <= srv && maze_oe;
            ra_q      <= a_addr;
            fw_vld    <= b_we;
            fw_addr   <= b_waddr;
            fw_data   <= b_wdata;
            r_vld     <= iss || go_dump;
            if (rd_pend) begin
                in_q <= maze_in;
            end
            if (m_wr && m_cur == CELL_FREE) begin
                path_count <= path_count + 12'd1;
            end
            if (iss) begin
                iss_cnt <= iss_cnt + 1'b1;
                if (iss_cnt == LAST) begin
                    iss_done <= 1'b1;
                end
            end
            if (state == ST_DUMP) begin
                // Output register refills from skid first, then from RAM.
                if (!dump_valid || pop) begin
                    if (sk_vld) begin
                        dump_cell <= sk_cell;
                        sk_vld    <= r_vld;
                        sk_cell   <= a_code;
                    end else begin
                        dump_valid <= r_vld;
                        if (r_vld) begin
                            dump_cell <= a_code;
                        end
                    end
                end else if (r_vld) begin
                    sk_vld  <= 1'b1;
                    sk_cell <= a_code;
                end
                if (pop) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= ST_SERVE;
                        dump_done <= 1'b1;
                    end
                end
            end
            if (ld_acc) begin
                cnt <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state      <= ST_SERVE;
                    load_done  <= 1'b1;
                    path_count <= '0;
                end
            end
            if (go_load) begin
                state <= ST_LOAD;
                cnt   <= '0;
            end
            if (go_dump) begin
                state      <= ST_DUMP;
                cnt        <= '0;
                iss_cnt    <= 12'd1;
                iss_done   <= 1'b0;
                dump_valid <= 1'b0;
                sk_vld     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_maze_memory.sv
// Directed bench for maze_memory: load, reads, marks, dump, resets.
// Expected grid contents are kept in a local reference array.
module tb_maze_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [1:0]  load_cell = '0;
    logic        load_ready;
    logic        load_done;
    logic [5:0]  row = '0;
    logic [5:0]  col = '0;
    logic        maze_oe = 1'b0;
    logic        maze_we = 1'b0;
    logic        maze_in;
    logic        dump_start = 1'b0;
    logic        dump_valid;
    logic [1:0]  dump_cell;
    logic        dump_ready = 1'b0;
    logic        dump_done;
    logic [11:0] path_count;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    logic [1:0] exp_mem [4096];
    logic [1:0] got_mem [4096];

    maze_memory dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_cell  (load_cell),
        .load_ready (load_ready),
        .load_done  (load_done),
        .row        (row),
        .col        (col),
        .maze_oe    (maze_oe),
        .maze_we    (maze_we),
        .maze_in    (maze_in),
        .dump_start (dump_start),
        .dump_valid (dump_valid),
        .dump_cell  (dump_cell),
        .dump_ready (dump_ready),
        .dump_done  (dump_done),
        .path_count (path_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] init_code(input int a);
        if (a == 5 * 64 + 7)   return 2'd1;
        if (a == 20 * 64 + 20) return 2'd3;
        if (a == 1)            return 2'd2;
        return 2'd0;
    endfunction

    task automatic load_all(input bit poke);
        int acc;
        bit seen;
        int early;
        acc = 0;
        seen = 0;
        early = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_busy", busy, 1);
        load_valid = 1'b1;
        for (int c = 0; c < 5000 && !seen; c++) begin
            load_cell = init_code(acc);
            if (poke) begin
                row = 6'd40;
                col = 6'd40;
                maze_oe = (acc == 10);
                maze_we = (acc == 10);
                if (acc == 20) begin
                    check("load_oe_maze_in", maze_in, 1);
                    check("load_we_path_count", path_count, 2);
                end
            end
            if (load_ready) acc++;
            tick();
            if (load_done) begin
                seen = 1;
                if (acc != 4096) early++;
            end
        end
        load_valid = 1'b0;
        maze_oe = 1'b0;
        maze_we = 1'b0;
        check("load_done_seen", seen, 1);
        check("load_accepts", acc, 4096);
        check("load_done_early", early, 0);
        check("load_serve_busy", busy, 0);
    endtask

    task automatic rd(input int r, input int c, input logic exp,
                      input string tag);
        row = 6'(r);
        col = 6'(c);
        maze_oe = 1'b1;
        tick();
        maze_oe = 1'b0;
        check({tag, "_n1"}, maze_in, exp);
        tick();
        check({tag, "_n2"}, maze_in, exp);
    endtask

    task automatic mark(input int r, input int c);
        row = 6'(r);
        col = 6'(c);
        maze_we = 1'b1;
        tick();
        maze_we = 1'b0;
    endtask

    initial begin
        int idx;
        int cyc;
        int data_err;
        int stall_err;
        int done_cnt;
        bit hold;
        bit acc;
        logic [1:0] held;

        for (int i = 0; i < 4096; i++) begin
            exp_mem[i] = (init_code(i) == 2'd3) ? 2'd1 : init_code(i);
        end

        tick();
        tick();
        check("rst_load_ready", load_ready, 0);
        check("rst_load_done", load_done, 0);
        check("rst_maze_in", maze_in, 0);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_dump_done", dump_done, 0);
        check("rst_busy", busy, 0);
        check("rst_dump_cell", dump_cell, 0);
        check("rst_path_count", path_count, 0);
        rst_n = 1'b1;
        tick();

        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            load_cell = 2'd1;
            tick();
        end
        check("midload_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        load_valid = 1'b0;
        check("midrst_load_ready", load_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_load_done", load_done, 0);
        check("midrst_maze_in", maze_in, 0);
        check("midrst_dump_valid", dump_valid, 0);
        check("midrst_path_count", path_count, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        load_all(1'b0);

        rd(5, 7, 1'b1, "rd_wall_5_7");
        rd(5, 8, 1'b0, "rd_free_5_8");
        rd(20, 20, 1'b1, "rd_code3_wall");
        rd(0, 1, 1'b0, "rd_path_0_1");

        mark(10, 10);
        mark(10, 10);
        mark(5, 7);
        mark(0, 1);
        tick();
        tick();
        check("marks_path_count", path_count, 1);
        exp_mem[10 * 64 + 10] = 2'd2;

        rd(5, 7, 1'b1, "rd_wall_after_mark");
        row = 6'd3;
        col = 6'd3;
        maze_oe = 1'b1;
        maze_we = 1'b1;
        tick();
        maze_oe = 1'b0;
        maze_we = 1'b0;
        check("same_cycle_maze_in", maze_in, 0);
        rd(3, 3, 1'b0, "rd_after_hazard");
        tick();
        check("hazard_path_count", path_count, 2);
        exp_mem[3 * 64 + 3] = 2'd2;

        dump_ready = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        check("dump_busy", busy, 1);
        tick();
        check("dump_first_valid", dump_valid, 1);

        idx = 0;
        cyc = 0;
        data_err = 0;
        stall_err = 0;
        done_cnt = 0;
        while (idx < 4096 && cyc < 20000) begin
            dump_ready = (cyc % 2) == 1;
            acc = dump_valid && dump_ready;
            if (acc) begin
                got_mem[idx] = dump_cell;
                if (dump_cell !== exp_mem[idx]) data_err++;
            end
            hold = dump_valid && !dump_ready;
            held = dump_cell;
            tick();
            cyc++;
            if (hold && (!dump_valid || dump_cell !== held)) stall_err++;
            if (dump_done) done_cnt++;
            if (acc) idx++;
        end
        check("dump_count", idx, 4096);
        check("dump_done_after_last", dump_done, 1);
        dump_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (dump_done) done_cnt++;
        end
        check("dump_data_errors", data_err, 0);
        check("dump_stall_errors", stall_err, 0);
        check("dump_done_count", done_cnt, 1);
        check("dump_cell_10_10", got_mem[10 * 64 + 10], 2);
        check("dump_cell_5_7", got_mem[5 * 64 + 7], 1);
        check("dump_cell_3_3", got_mem[3 * 64 + 3], 2);
        check("dump_cell_20_20", got_mem[20 * 64 + 20], 1);
        check("dump_end_busy", busy, 0);

        rd(5, 7, 1'b1, "rd_before_reload");
        load_all(1'b1);
        check("reload_path_count", path_count, 0);
        rd(40, 40, 1'b0, "rd_after_reload");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
